// File: rtl/tube_fifo_pkg.sv
`default_nettype none
// ============================================================================
// tube_fifo_pkg : shared phase encoding, reset-phase helper, parameter limits
// Revision: 1.0
// ============================================================================
package tube_fifo_pkg;

  typedef logic [0:0] phase_t;

  localparam logic [0:0] PH_FILL  = 1'b0;
  localparam logic [0:0] PH_DRAIN = 1'b1;

  localparam int C_MIN_A_WIDTH = 1;
  localparam int C_MIN_BLOCK   = 1;

  function automatic phase_t reset_phase(input int preload, input int block);
    return (preload >= block) ? PH_DRAIN : PH_FILL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tube_wrap_ptr.sv
`default_nettype none
// ============================================================================
// tube_wrap_ptr : modulo-DEPTH pointer with increment, sync clear, async reset
// Revision: 1.0
// ============================================================================
module tube_wrap_ptr
  import tube_fifo_pkg::*;
#(
  parameter int A_WIDTH = 1,
  parameter int RST_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [A_WIDTH-1:0] ptr_o
);

  localparam logic [A_WIDTH-1:0] c_rst_val = A_WIDTH'(RST_VAL);

  logic [A_WIDTH-1:0] ptr_q;
  logic [A_WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= c_rst_val;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/tube_sync_fifo.sv
`default_nettype none
// ============================================================================
// tube_sync_fifo : single-clock register FIFO with byte/block status modes
// Revision: 1.0
// ============================================================================
module tube_sync_fifo
  import tube_fifo_pkg::*;
#(
  parameter int                 D_WIDTH      = 8,
  parameter int                 A_WIDTH      = 1,
  parameter int                 BLOCK        = 2,
  parameter int                 PRELOAD      = 0,
  parameter logic [D_WIDTH-1:0] PRELOAD_DATA = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data,
  input  logic               block_mode,
  input  logic               flush,
  input  logic               clr_err,
  output logic [A_WIDTH:0]   count,
  output logic               empty,
  output logic               full,
  output logic               data_available,
  output logic               not_full,
  output logic               overrun,
  output logic               underrun
);

  localparam int             DEPTH         = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] c_depth     = (A_WIDTH+1)'(DEPTH);
  localparam logic [A_WIDTH:0] c_block     = (A_WIDTH+1)'(BLOCK);
  localparam logic [A_WIDTH:0] c_count_rst = (A_WIDTH+1)'(PRELOAD);
  localparam phase_t         c_phase_rst   = reset_phase(PRELOAD, BLOCK);

  generate
    if (A_WIDTH < C_MIN_A_WIDTH || BLOCK < C_MIN_BLOCK || BLOCK > DEPTH ||
        PRELOAD < 0 || PRELOAD > DEPTH) begin : g_bad_params
      $error("tube_sync_fifo: parameter out of range");
    end
  endgenerate

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH:0]   count_q;
  logic [A_WIDTH:0]   count_d;
  phase_t             phase_q;
  phase_t             phase_d;
  logic               overrun_q;
  logic               overrun_d;
  logic               underrun_q;
  logic               underrun_d;

  logic empty_w;
  logic full_w;
  logic wr_acc;
  logic rd_acc;
  logic wr_rej;
  logic rd_rej;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == c_depth);

  // Acceptance uses pre-edge occupancy only; flush silences both requests.
  assign wr_acc = wr_en && !full_w  && !flush;
  assign rd_acc = rd_en && !empty_w && !flush;
  assign wr_rej = wr_en &&  full_w  && !flush;
  assign rd_rej = rd_en &&  empty_w && !flush;

  tube_wrap_ptr #(
    .A_WIDTH (A_WIDTH),
    .RST_VAL (PRELOAD % DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_acc),
    .clr_i (flush),
    .ptr_o (wr_ptr)
  );

  tube_wrap_ptr #(
    .A_WIDTH (A_WIDTH),
    .RST_VAL (0)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_acc),
    .clr_i (flush),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  // Hysteresis evaluated on next-state count so status moves on the same edge.
  always_comb begin
    phase_d = phase_q;
    if (flush) begin
      phase_d = PH_FILL;
    end else if (phase_q == PH_FILL && count_d >= c_block) begin
      phase_d = PH_DRAIN;
    end else if (phase_q == PH_DRAIN && count_d == '0) begin
      phase_d = PH_FILL;
    end
  end

  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (clr_err) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (wr_rej) begin
      overrun_d = 1'b1;
    end
    if (rd_rej) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= c_count_rst;
      phase_q    <= c_phase_rst;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      phase_q    <= phase_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < PRELOAD) ? PRELOAD_DATA : '0;
      end
    end else if (wr_acc) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data        = mem_q[rd_ptr];
  assign count          = count_q;
  assign empty          = empty_w;
  assign full           = full_w;
  assign data_available = block_mode ? (phase_q == PH_DRAIN) : !empty_w;
  assign not_full       = block_mode ? (phase_q == PH_FILL)  : !full_w;
  assign overrun        = overrun_q;
  assign underrun       = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tube_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_tube_sync_fifo : scoreboard bench for a DEPTH=2 preloaded and a DEPTH=4 FIFO
// Revision: 1.0
// ============================================================================
module tb_tube_sync_fifo;

  logic clk;
  logic rst;

  // DEPTH=2, BLOCK=2, PRELOAD=1 of 8'hAA
  logic       a_wr_en, a_rd_en, a_block_mode, a_flush, a_clr_err;
  logic [7:0] a_wr_data, a_rd_data;
  logic [1:0] a_count;
  logic       a_empty, a_full, a_da, a_nf, a_ovr, a_und;

  // DEPTH=4, BLOCK=2, PRELOAD=0
  logic       b_wr_en, b_rd_en, b_block_mode, b_flush, b_clr_err;
  logic [7:0] b_wr_data, b_rd_data;
  logic [2:0] b_count;
  logic       b_empty, b_full, b_da, b_nf, b_ovr, b_und;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit ph_b, ovr_b, und_b;

  tube_sync_fifo #(.D_WIDTH(8), .A_WIDTH(1), .BLOCK(2), .PRELOAD(1), .PRELOAD_DATA(8'hAA)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
    .rd_data(a_rd_data), .block_mode(a_block_mode), .flush(a_flush), .clr_err(a_clr_err),
    .count(a_count), .empty(a_empty), .full(a_full), .data_available(a_da),
    .not_full(a_nf), .overrun(a_ovr), .underrun(a_und)
  );

  tube_sync_fifo #(.D_WIDTH(8), .A_WIDTH(2), .BLOCK(2), .PRELOAD(0), .PRELOAD_DATA(8'h00)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
    .rd_data(b_rd_data), .block_mode(b_block_mode), .flush(b_flush), .clr_err(b_clr_err),
    .count(b_count), .empty(b_empty), .full(b_full), .data_available(b_da),
    .not_full(b_nf), .overrun(b_ovr), .underrun(b_und)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_da_b();
    return b_block_mode ? ph_b : (qb.size() != 0);
  endfunction

  function automatic bit exp_nf_b();
    return b_block_mode ? !ph_b : (qb.size() != 4);
  endfunction

  task automatic cyc_a(input bit wr, input logic [7:0] d, input bit rd);
    int n = qa.size();
    a_wr_en = wr; a_wr_data = d; a_rd_en = rd;
    if (rd && n > 0) void'(qa.pop_front());
    if (wr && n < 2) qa.push_back(d);
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_rd_en = 1'b0;
  endtask

  task automatic cyc_b(input bit wr, input logic [7:0] d, input bit rd, input bit fl, input bit ce);
    int n = qb.size();
    bit wacc = 1'b0;
    bit racc = 1'b0;
    b_wr_en = wr; b_wr_data = d; b_rd_en = rd; b_flush = fl; b_clr_err = ce;
    if (ce) begin ovr_b = 1'b0; und_b = 1'b0; end
    if (fl) begin
      qb.delete();
      ph_b = 1'b0;
    end else begin
      wacc = wr && (n < 4);
      racc = rd && (n > 0);
      if (racc) void'(qb.pop_front());
      if (wacc) qb.push_back(d);
      if (wr && !wacc) ovr_b = 1'b1;
      if (rd && !racc) und_b = 1'b1;
      if (!ph_b && qb.size() >= 2) ph_b = 1'b1;
      else if (ph_b && qb.size() == 0) ph_b = 1'b0;
    end
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_flush = 1'b0; b_clr_err = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL rst_a_count: got %0d exp 1", a_count); end
    checks++; if (a_rd_data !== qa[0]) begin errors++; $display("FAIL rst_a_rd_data: got %h exp %h", a_rd_data, qa[0]); end
    checks++; if (a_empty !== 1'b0) begin errors++; $display("FAIL rst_a_empty: got %b exp 0", a_empty); end
    a_block_mode = 1'b1; #1;
    checks++; if (a_da !== 1'b0) begin errors++; $display("FAIL rst_a_blk_da: got %b exp 0", a_da); end
    checks++; if (a_nf !== 1'b1) begin errors++; $display("FAIL rst_a_blk_nf: got %b exp 1", a_nf); end
    a_block_mode = 1'b0; #1;
    checks++; if (a_da !== 1'b1) begin errors++; $display("FAIL rst_a_byte_da: got %b exp 1", a_da); end
    checks++; if (a_nf !== 1'b1) begin errors++; $display("FAIL rst_a_byte_nf: got %b exp 1", a_nf); end
    checks++; if (b_count !== 3'd0) begin errors++; $display("FAIL rst_b_count: got %0d exp 0", b_count); end
    checks++; if (b_empty !== 1'b1 || b_full !== 1'b0) begin errors++; $display("FAIL rst_b_empty_full: got %b%b exp 10", b_empty, b_full); end
    checks++; if (b_da !== 1'b0 || b_nf !== 1'b1) begin errors++; $display("FAIL rst_b_status: got da=%b nf=%b exp da=0 nf=1", b_da, b_nf); end
    checks++; if (b_ovr !== 1'b0 || b_und !== 1'b0) begin errors++; $display("FAIL rst_b_err: got %b%b exp 00", b_ovr, b_und); end
  endtask

  task automatic test_block_hysteresis();
    checks++; if (a_rd_data !== qa[0]) begin errors++; $display("FAIL hyst_preload_pop: got %h exp %h", a_rd_data, qa[0]); end
    cyc_a(1'b0, 8'h00, 1'b1);
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL hyst_empty: got %0d exp 0", a_count); end
    a_block_mode = 1'b1;
    cyc_a(1'b1, 8'h11, 1'b0);
    checks++; if (a_da !== 1'b0 || a_nf !== 1'b1) begin errors++; $display("FAIL hyst_w1: got da=%b nf=%b exp da=0 nf=1", a_da, a_nf); end
    cyc_a(1'b1, 8'h22, 1'b0);
    checks++; if (a_da !== 1'b1 || a_nf !== 1'b0) begin errors++; $display("FAIL hyst_w2: got da=%b nf=%b exp da=1 nf=0", a_da, a_nf); end
    checks++; if (a_rd_data !== qa[0]) begin errors++; $display("FAIL hyst_rd1_data: got %h exp %h", a_rd_data, qa[0]); end
    cyc_a(1'b0, 8'h00, 1'b1);
    checks++; if (a_rd_data !== qa[0]) begin errors++; $display("FAIL hyst_rd2_data: got %h exp %h", a_rd_data, qa[0]); end
    checks++; if (a_da !== 1'b1 || a_nf !== 1'b0) begin errors++; $display("FAIL hyst_r1: got da=%b nf=%b exp da=1 nf=0", a_da, a_nf); end
    cyc_a(1'b0, 8'h00, 1'b1);
    checks++; if (a_da !== 1'b0 || a_nf !== 1'b1) begin errors++; $display("FAIL hyst_r2: got da=%b nf=%b exp da=0 nf=1", a_da, a_nf); end
  endtask

  task automatic test_overrun_underrun();
    for (int i = 0; i < 4; i++) cyc_b(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    checks++; if (b_count !== 3'd4 || b_full !== 1'b1 || b_nf !== 1'b0) begin errors++; $display("FAIL ovr_fill: got cnt=%0d full=%b nf=%b exp 4 1 0", b_count, b_full, b_nf); end
    cyc_b(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checks++; if (b_count !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d exp 4", b_count); end
    checks++; if (b_ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b exp 1", b_ovr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_rd_data !== qb[0]) begin errors++; $display("FAIL ovr_contents: got %h exp %h", b_rd_data, qb[0]); end
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (b_und !== 1'b1 || b_count !== 3'd0) begin errors++; $display("FAIL und_flag: got und=%b cnt=%0d exp 1 0", b_und, b_count); end
    cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (b_und !== und_b || b_ovr !== ovr_b) begin errors++; $display("FAIL clr_vs_new: got und=%b ovr=%b exp und=%b ovr=%b", b_und, b_ovr, und_b, ovr_b); end
    cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (b_und !== 1'b0 || b_ovr !== 1'b0) begin errors++; $display("FAIL clr_err: got und=%b ovr=%b exp 0 0", b_und, b_ovr); end
  endtask

  task automatic test_simultaneous();
    cyc_b(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    cyc_b(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    checks++; if (b_rd_data !== qb[0]) begin errors++; $display("FAIL sim_head: got %h exp %h", b_rd_data, qb[0]); end
    cyc_b(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
    checks++; if (b_count !== 3'd2) begin errors++; $display("FAIL sim_count: got %0d exp 2", b_count); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (b_rd_data !== qb[0]) begin errors++; $display("FAIL sim_order: got %h exp %h", b_rd_data, qb[0]); end
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    cyc_b(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    checks++; if (b_count !== 3'd1 || b_rd_data !== 8'h07) begin errors++; $display("FAIL sim_empty: got cnt=%0d data=%h exp 1 07", b_count, b_rd_data); end
    checks++; if (b_und !== 1'b1) begin errors++; $display("FAIL sim_empty_und: got %b exp 1", b_und); end
    cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc_b(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
    cyc_b(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    checks++; if (b_count !== 3'd3 || b_ovr !== 1'b1) begin errors++; $display("FAIL sim_full: got cnt=%0d ovr=%b exp 3 1", b_count, b_ovr); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_rd_data !== qb[0]) begin errors++; $display("FAIL sim_full_order: got %h exp %h", b_rd_data, qb[0]); end
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    cyc_b(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc_b(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 10; i++) begin
      checks++; if (b_rd_data !== qb[0]) begin errors++; $display("FAIL wrap_data: got %0d exp %0d", b_rd_data, qb[0]); end
      cyc_b(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (b_rd_data !== qb[0]) begin errors++; $display("FAIL wrap_tail: got %0d exp %0d", b_rd_data, qb[0]); end
      cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (b_count !== 3'(qb.size()) || b_empty !== 1'b1) begin errors++; $display("FAIL wrap_end: got cnt=%0d empty=%b exp 0 1", b_count, b_empty); end
  endtask

  task automatic test_flush();
    b_block_mode = 1'b1;
    for (int i = 0; i < 5; i++) cyc_b(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    cyc_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (b_count !== 3'd3 || b_da !== exp_da_b() || b_nf !== exp_nf_b()) begin errors++; $display("FAIL flush_pre: got cnt=%0d da=%b nf=%b exp 3 %b %b", b_count, b_da, b_nf, exp_da_b(), exp_nf_b()); end
    cyc_b(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    checks++; if (b_count !== 3'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL flush_count: got cnt=%0d empty=%b exp 0 1", b_count, b_empty); end
    checks++; if (b_da !== 1'b0 || b_nf !== 1'b1) begin errors++; $display("FAIL flush_status: got da=%b nf=%b exp 0 1", b_da, b_nf); end
    checks++; if (b_ovr !== ovr_b || b_und !== und_b) begin errors++; $display("FAIL flush_err: got ovr=%b und=%b exp %b %b", b_ovr, b_und, ovr_b, und_b); end
    cyc_b(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    checks++; if (b_rd_data !== qb[0] || b_count !== 3'd1) begin errors++; $display("FAIL flush_after: got data=%h cnt=%0d exp %h 1", b_rd_data, b_count, qb[0]); end
    cyc_b(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    cyc_b(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (b_count !== 3'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL arst_b: got cnt=%0d empty=%b exp 0 1", b_count, b_empty); end
    checks++; if (a_count !== 2'd1 || a_rd_data !== 8'hAA) begin errors++; $display("FAIL arst_a: got cnt=%0d data=%h exp 1 aa", a_count, a_rd_data); end
    #2 rst = 1'b0;
    qb.delete(); ph_b = 1'b0; ovr_b = 1'b0; und_b = 1'b0;
    qa.delete(); qa.push_back(8'hAA);
    @(posedge clk); #1;
    checks++; if (b_ovr !== 1'b0 || b_und !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL arst_release: got ovr=%b und=%b cnt=%0d exp 0 0 0", b_ovr, b_und, b_count); end
  endtask

  initial begin
    rst = 1'b0;
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_block_mode = 1'b0; a_flush = 1'b0; a_clr_err = 1'b0; a_wr_data = 8'h00;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_block_mode = 1'b0; b_flush = 1'b0; b_clr_err = 1'b0; b_wr_data = 8'h00;
    ph_b = 1'b0; ovr_b = 1'b0; und_b = 1'b0;
    qa.push_back(8'hAA);
    #3 rst = 1'b1;
    #10 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_block_hysteresis();
    test_overrun_underrun();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
